wptr_full_ctrl: RTL and testbench

- Write-side pointer and flag controller for the team's dual-clock asynchronous FIFO.
- Lives entirely in the write clock domain and drives the write address and write enable of the FIFO memory.
- Publishes a Gray-coded write pointer toward the read-domain 2-flop synchronizer.
- Consumes the read pointer after it has passed through the write-domain 2-flop synchronizer, and from it derives the full, almost-full, level and overflow status.

---
 rtl/wptr_full_ctrl_if.sv | 39 +++
 rtl/wptr_full_ctrl.sv | 85 ++++++++
 tb/tb_wptr_full_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wptr_full_ctrl_if.sv
// Bundle of write-side FIFO control signals between the producer, memory and wptr_full_ctrl.
// Optional macro WPTR_LEVEL_EN adds the registered occupancy signal wlevel.
interface wptr_full_ctrl_if #(
  parameter int ASIZE = 4
);
  logic             winc;
  logic [ASIZE:0]   wq2_rptr;
  logic             wovf_clr;
  logic             wen;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr;
  logic             wfull;
  logic             walmost_full;
  logic             wovf;
`ifdef WPTR_LEVEL_EN
  logic [ASIZE:0]   wlevel;
`endif

  // master is the controller itself; slave is the producer/memory/synchronizer side
`ifdef WPTR_LEVEL_EN
  modport master (
    input  winc, wq2_rptr, wovf_clr,
    output wen, waddr, wptr, wfull, walmost_full, wovf, wlevel
  );
  modport slave (
    output winc, wq2_rptr, wovf_clr,
    input  wen, waddr, wptr, wfull, walmost_full, wovf, wlevel
  );
`else
  modport master (
    input  winc, wq2_rptr, wovf_clr,
    output wen, waddr, wptr, wfull, walmost_full, wovf
  );
  modport slave (
    output winc, wq2_rptr, wovf_clr,
    input  wen, waddr, wptr, wfull, walmost_full, wovf
  );
`endif
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full and sticky-overflow controller for the async FIFO.
// Optional macro WPTR_LEVEL_EN exposes the registered occupancy on bus.wlevel.
module wptr_full_ctrl #(
  parameter int ASIZE        = 4,
  parameter int AFULL_THRESH = 12
) (
  input logic              clk,
  input logic              rst,
  wptr_full_ctrl_if.master bus
);

  localparam logic [ASIZE:0] AFULL_VAL = (ASIZE+1)'(AFULL_THRESH);

  logic [ASIZE:0] r_wbin;
  logic [ASIZE:0] r_wptr;
  logic           r_wfull;
  logic           r_walmost;
  logic           r_wovf;

  logic           w_wen;
  logic [ASIZE:0] w_wbinNext;
  logic [ASIZE:0] w_wgrayNext;
  logic [ASIZE:0] w_rbin;
  logic [ASIZE:0] w_levelNext;
  logic [ASIZE:0] w_fullCmp;

  assign w_wen       = bus.winc & ~r_wfull & ~rst;
  assign w_wbinNext  = r_wbin + {{ASIZE{1'b0}}, w_wen};
  assign w_wgrayNext = (w_wbinNext >> 1) ^ w_wbinNext;

  // Full when our next Gray pointer equals the read pointer with its two MSBs inverted
  assign w_fullCmp = {~bus.wq2_rptr[ASIZE:ASIZE-1], bus.wq2_rptr[ASIZE-2:0]};

  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      w_rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  assign w_levelNext = w_wbinNext - w_rbin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin    <= '0;
      r_wptr    <= '0;
      r_wfull   <= 1'b0;
      r_walmost <= 1'b0;
      r_wovf    <= 1'b0;
    end else begin
      r_wbin    <= w_wbinNext;
      r_wptr    <= w_wgrayNext;
      r_wfull   <= (w_wgrayNext == w_fullCmp);
      r_walmost <= (w_levelNext >= AFULL_VAL);
      // A dropped write outranks a simultaneous clear so no overflow is ever lost
      if (bus.winc && r_wfull) begin
        r_wovf <= 1'b1;
      end else if (bus.wovf_clr) begin
        r_wovf <= 1'b0;
      end
    end
  end

`ifdef WPTR_LEVEL_EN
  logic [ASIZE:0] r_wlevel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wlevel <= '0;
    end else begin
      r_wlevel <= w_levelNext;
    end
  end

  assign bus.wlevel = r_wlevel;
`endif

  assign bus.wen          = w_wen;
  assign bus.waddr        = r_wbin[ASIZE-1:0];
  assign bus.wptr         = r_wptr;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost;
  assign bus.wovf         = r_wovf;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl with ASIZE=4, AFULL_THRESH=12.
// wlevel checks are active only when WPTR_LEVEL_EN is defined.
module tb_wptr_full_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   model;
  logic [4:0] prevPtr;

  wptr_full_ctrl_if #(.ASIZE(4)) bus ();

  wptr_full_ctrl #(
    .ASIZE(4),
    .AFULL_THRESH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic inc, input logic [4:0] rptr, input logic clr);
    rst          = r;
    bus.winc     = inc;
    bus.wq2_rptr = rptr;
    bus.wovf_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkLevel(input string tag, input int exp);
`ifdef WPTR_LEVEL_EN
    checkOutput(tag, 32'(bus.wlevel), 32'(exp));
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // reset with active write request and random read pointer
    applyStimulus(1'b1, 1'b1, 5'($urandom), 1'b0);
    #1;
    checkOutput("rst_wen_pre", 32'(bus.wen), 0);
    tick();
    tick();
    checkOutput("rst_wen", 32'(bus.wen), 0);
    checkOutput("rst_wptr", 32'(bus.wptr), 0);
    checkOutput("rst_waddr", 32'(bus.waddr), 0);
    checkOutput("rst_wfull", 32'(bus.wfull), 0);
    checkOutput("rst_walmost", 32'(bus.walmost_full), 0);
    checkOutput("rst_wovf", 32'(bus.wovf), 0);
    checkLevel("rst_wlevel", 0);

    // fill 16 entries against a read pointer parked at zero
    applyStimulus(1'b0, 1'b1, 5'b00000, 1'b0);
    #1;
    checkOutput("fill_wen0", 32'(bus.wen), 1);
    checkOutput("fill_waddr0", 32'(bus.waddr), 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput($sformatf("fill_waddr%0d", k), 32'(bus.waddr), 32'(k % 16));
      checkOutput($sformatf("fill_wptr%0d", k), 32'(bus.wptr), 32'(gray(k)));
      checkOutput($sformatf("fill_walmost%0d", k), 32'(bus.walmost_full), 32'(k >= 12));
      checkOutput($sformatf("fill_wfull%0d", k), 32'(bus.wfull), 32'(k == 16));
      checkLevel($sformatf("fill_wlevel%0d", k), k);
    end
    checkOutput("fill_wptr_full", 32'(bus.wptr), 32'h18);
    checkOutput("fill_wovf", 32'(bus.wovf), 0);

    // overflow attempt while full
    applyStimulus(1'b0, 1'b1, 5'b00000, 1'b0);
    #1;
    checkOutput("ovf_wen", 32'(bus.wen), 0);
    tick();
    checkOutput("ovf_wptr", 32'(bus.wptr), 32'h18);
    checkOutput("ovf_set", 32'(bus.wovf), 1);
    checkOutput("ovf_wfull", 32'(bus.wfull), 1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0);
    tick();
    checkOutput("ovf_hold", 32'(bus.wovf), 1);
    applyStimulus(1'b0, 1'b1, 5'b00000, 1'b1);
    tick();
    checkOutput("ovf_set_wins", 32'(bus.wovf), 1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1);
    tick();
    checkOutput("ovf_clear", 32'(bus.wovf), 0);

    // read side catches up: four then five entries consumed
    applyStimulus(1'b0, 1'b0, 5'b00110, 1'b0);
    tick();
    checkOutput("drain4_wfull", 32'(bus.wfull), 0);
    checkOutput("drain4_walmost", 32'(bus.walmost_full), 1);
    checkLevel("drain4_wlevel", 12);
    applyStimulus(1'b0, 1'b0, 5'b00111, 1'b0);
    tick();
    checkOutput("drain5_walmost", 32'(bus.walmost_full), 0);
    checkOutput("drain5_wfull", 32'(bus.wfull), 0);
    checkLevel("drain5_wlevel", 11);

    // wrap: reader trails the writer by two entries
    model = 16;
    applyStimulus(1'b0, 1'b0, gray(14), 1'b0);
    tick();
    checkLevel("wrap_pre_wlevel", 2);
    prevPtr = bus.wptr;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, 1'b1, gray(model - 1), 1'b0);
      #1;
      checkOutput($sformatf("wrap_wen%0d", k), 32'(bus.wen), 1);
      tick();
      model = (model + 1) % 32;
      checkOutput($sformatf("wrap_wptr%0d", k), 32'(bus.wptr), 32'(gray(model)));
      checkOutput($sformatf("wrap_onebit%0d", k), 32'($countones(bus.wptr ^ prevPtr)), 1);
      checkOutput($sformatf("wrap_wfull%0d", k), 32'(bus.wfull), 0);
      checkLevel($sformatf("wrap_wlevel%0d", k), 2);
      prevPtr = bus.wptr;
    end
    checkOutput("wrap_end_waddr", 32'(bus.waddr), 32'h8);

    // reset in the middle of operation at level 7
    applyStimulus(1'b0, 1'b0, gray(17), 1'b0);
    tick();
    checkOutput("mid_walmost", 32'(bus.walmost_full), 0);
    checkLevel("mid_wlevel", 7);
    applyStimulus(1'b1, 1'b1, gray(17), 1'b0);
    #1;
    checkOutput("mid_rst_wen", 32'(bus.wen), 0);
    tick();
    checkOutput("mid_rst_wptr", 32'(bus.wptr), 0);
    checkOutput("mid_rst_waddr", 32'(bus.waddr), 0);
    checkOutput("mid_rst_wfull", 32'(bus.wfull), 0);
    checkOutput("mid_rst_walmost", 32'(bus.walmost_full), 0);
    checkOutput("mid_rst_wovf", 32'(bus.wovf), 0);
    checkLevel("mid_rst_wlevel", 0);
    applyStimulus(1'b0, 1'b1, 5'b00000, 1'b0);
    #1;
    checkOutput("resume_wen", 32'(bus.wen), 1);
    checkOutput("resume_waddr0", 32'(bus.waddr), 0);
    tick();
    checkOutput("resume_waddr1", 32'(bus.waddr), 1);
    checkOutput("resume_wptr1", 32'(bus.wptr), 1);
    checkLevel("resume_wlevel", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
